// File: rtl/reg_file_mp.sv
// Multi-port integer register file with hardwired-zero x0, highest-port-wins
// write merging, optional write-to-read bypass and a per-register busy scoreboard.
module reg_file_mp #(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 32,
  parameter  int NUM_RD = 2,
  parameter  int NUM_WR = 1,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NUM_RD*AW-1:0]     rd_addr_i,
  output logic [NUM_RD*XLEN-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*AW-1:0]     wr_addr_i,
  input  logic [NUM_WR*XLEN-1:0]   wr_data_i,
  input  logic                     rsv_en_i,
  input  logic [AW-1:0]            rsv_addr_i,
  output logic                     rsv_ok_o,
  output logic [NREGS-1:0]         busy_o
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;

  logic [NREGS-1:0] w_wen;
  logic [XLEN-1:0]  w_wdata [NREGS];
  logic [NREGS-1:0] w_busy_nxt;
  logic             w_rsv_ok;

  // Per-register write decode; later ports overwrite earlier ones so the highest index wins.
  always_comb begin
    w_wen = '0;
    for (int r = 0; r < NREGS; r++) w_wdata[r] = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en_i[j]) begin
        w_wen[wr_addr_i[j*AW +: AW]]   = 1'b1;
        w_wdata[wr_addr_i[j*AW +: AW]] = wr_data_i[j*XLEN +: XLEN];
      end
    end
    w_wen[0] = 1'b0;
  end

  always_comb begin
    logic [AW-1:0] ra;
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = rd_addr_i[k*AW +: AW];
      if (ra != '0) begin
        if ((BYPASS != 0) && w_wen[ra]) begin
          rd_data_o[k*XLEN +: XLEN] = w_wdata[ra];
          rd_busy_o[k]              = 1'b0;
        end else begin
          rd_data_o[k*XLEN +: XLEN] = r_regs[ra];
          rd_busy_o[k]              = r_busy[ra];
        end
      end
    end
  end

  // A register being written this cycle is free to hand to a new producer.
  assign w_rsv_ok = (rsv_addr_i == '0) | ~r_busy[rsv_addr_i] | w_wen[rsv_addr_i];
  assign rsv_ok_o = w_rsv_ok;

  // Reservation is applied after release so a same-cycle reserve keeps the bit set.
  always_comb begin
    w_busy_nxt = r_busy & ~w_wen;
    if (rsv_en_i && w_rsv_ok && (rsv_addr_i != '0))
      w_busy_nxt[rsv_addr_i] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  assign busy_o = r_busy;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_busy <= '0;
      for (int r = 0; r < NREGS; r++) r_regs[r] <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      for (int r = 0; r < NREGS; r++)
        if (w_wen[r]) r_regs[r] <= w_wdata[r];
    end
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port integer register file for the core pipeline. It generalises the current two-port register file with configurable width, depth and read/write port count. It adds a hardwired-zero register 0, deterministic write-collision priority, optional write-to-read bypass, and a per-register busy scoreboard for in-flight producers. It sits between decode (read and reserve) and writeback (write and release).

Parameters:
XLEN, 32, register width in bits
NREGS, 32, number of architectural registers (power of two, >=2); AW = $clog2(NREGS)
NUM_RD, 2, number of read ports
NUM_WR, 1, number of write ports
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return pre-write value

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_n_i  in  1  reset, asynchronous assert, active-low
rd_addr_i  in  NUM_RD*AW  read addresses, port k at [k*AW +: AW]
rd_data_o  out  NUM_RD*XLEN  read data, port k at [k*XLEN +: XLEN]
rd_busy_o  out  NUM_RD  addressed register has a pending producer
wr_en_i  in  NUM_WR  write enables
wr_addr_i  in  NUM_WR*AW  write addresses
wr_data_i  in  NUM_WR*XLEN  write data
rsv_en_i  in  1  reserve request: mark rsv_addr_i busy
rsv_addr_i  in  AW  register to reserve
rsv_ok_o  out  1  reservation accepted this cycle
busy_o  out  NREGS  full scoreboard vector, bit r = register r busy

Behaviour:
- Reset (rst_n_i=0, async): all registers = 0, all busy bits = 0.
  - rd_data_o = 0, rd_busy_o = 0, busy_o = 0, rsv_ok_o = 1 (combinational on cleared state).
  - Reset mid-operation discards pending writes and reservations.
- Register 0:
  - Always reads 0.
  - Writes to it are ignored.
  - Reserving it returns rsv_ok_o=1 but sets no busy bit; busy_o[0] is always 0.
- Reads: combinational, zero latency, fully independent per port.
- Writes: take effect at the rising edge when wr_en_i[j]=1.
  - Two or more ports writing the same address in one cycle: highest-indexed port wins.
- Bypass:
  - BYPASS=1: if any enabled write port targets a nonzero rd_addr in the same cycle, rd_data_o for that port = that write data (highest-indexed write port wins) and rd_busy_o for that port = 0.
  - BYPASS=0: rd_data_o shows the stored value; rd_busy_o = stored busy bit.
- Scoreboard release: an enabled write to register r clears busy[r] at the edge. Writing a non-busy register is legal; busy stays 0.
- Scoreboard reserve:
  - rsv_ok_o = (rsv_addr_i==0) | ~busy[rsv_addr_i] | (register being written this cycle). Combinational.
  - rsv_en_i & rsv_ok_o: busy[rsv_addr_i] = 1 at the next edge.
  - rsv_en_i & ~rsv_ok_o: no state change; requester holds and retries.
  - rsv_ok_o is valid even when rsv_en_i=0.
- Simultaneous release and reserve of the same register: reservation wins, busy stays 1. The old producer retires and the new producer owns the register.
- busy_o and rd_busy_o are registered state viewed combinationally. A reservation is visible from the cycle after acceptance.

Test Plan:
- Reset: assert rst_n_i=0 asynchronously mid-cycle after writing r5=0xDEADBEEF -> immediately rd_data_o=0 and busy_o=0; after release, reading r5 -> 0.
- x0: write r0=0x12345678, then read r0 on both ports -> 0; rsv_en_i on r0 -> rsv_ok_o=1 and busy_o stays 0.
- Collision (NUM_WR=2): both ports write r7 with 0xAAAA0001 and 0xBBBB0002 -> next cycle r7=0xBBBB0002.
- Bypass: BYPASS=1 with r3=0x10 stored; same cycle write r3=0x20 and read r3 -> rd_data_o=0x20. With BYPASS=0 the same stimulus -> 0x10, then 0x20 next cycle.
- Scoreboard: reserve r9 -> busy_o[9]=1 next cycle. Second reserve of r9 -> rsv_ok_o=0 with no change. Write r9 -> busy cleared next cycle, data visible.
- Reserve plus release same cycle: r9 busy, write r9=0x55 and rsv_en_i r9 together -> rsv_ok_o=1, busy_o[9] stays 1, r9=0x55.
